// File: rtl/chu_vcap_pkg.sv
// Shared types and constants for the VGA capture core.
package chu_vcap_pkg;

  // Capture FSM states (WAIT_VS, IN_VS, V_BACK, H_BACK, H_ACT, H_WAIT).
  typedef enum logic [2:0] {
    StWaitVs,
    StInVs,
    StVBack,
    StHBack,
    StHAct,
    StHWait
  } vcap_state_t;

  // ctrl_reg bit positions and its slot address.
  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlOvfClrBit = 1;
  localparam logic [1:0]  CtrlAddr      = 2'd0;

endpackage

// File: rtl/chu_vcap_fifo.sv
// Register-based synchronous FIFO for captured pixels. Output data comes straight
// from the storage registers; a push into a full FIFO is accepted only when a pop
// frees the slot in the same cycle, otherwise the word is dropped.
module chu_vcap_fifo #(
  parameter int unsigned Width = 13,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_pop, do_write;

  // Flags, accept/drop decision and next pointer/storage values.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
               (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_write = push_i && (!full_o || do_pop);
    drop_o   = push_i && !do_write;
    wr_ptr_d = wr_ptr_q + (AddrW + 1)'(do_write);
    rd_ptr_d = rd_ptr_q + (AddrW + 1)'(do_pop);
    mem_d    = mem_q;
    if (do_write) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  // Storage and pointers; storage is cleared so the output reads 0 in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/chu_vga_capture_core.sv
// VGA frame capture: follows the incoming sync signals, pushes every active pixel
// as {rgb, frame_start} into a small FIFO and streams it out with valid/ready.
// Optional build macro VCAP_OVERFLOW_EN adds the sticky overflow flag and its
// ctrl bit1 clear; without it overflow reads 0 but full-FIFO pixels still drop.
module chu_vga_capture_core
  import chu_vcap_pkg::*;
#(
  parameter int unsigned CD      = 12,
  parameter int unsigned HMAX    = 640,
  parameter int unsigned VMAX    = 480,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_tick,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [CD-1:0] rgb_in,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [CD:0]   so_data,
  output logic          so_valid,
  input  logic          so_ready,
  output logic          overflow
);

  // Porch counter starts at 1 on entry to H_BACK because the hsync rising-edge
  // tick is itself the first back-porch tick (assumes H_BP >= 2).
  localparam logic [9:0] HBpLast = 10'(H_BP - 1);
  localparam logic [9:0] VBpLast = 10'(V_BP - 1);
  localparam logic [9:0] XLast   = 10'(HMAX - 1);
  localparam logic [9:0] YLast   = 10'(VMAX - 1);

  vcap_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d, cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        ctrl_wr, hs_rise, vs_rise, vs_fall;
  logic        push, frame_start;
  logic        fifo_full, fifo_empty, drop;

  // Control register write decode and sync sampling on pixel ticks.
  always_comb begin
    ctrl_wr = cs && write && (addr[1:0] == CtrlAddr);
    en_d    = ctrl_wr ? wr_data[CtrlEnBit] : en_q;
    hs_d    = pix_tick ? hsync_in : hs_q;
    vs_d    = pix_tick ? vsync_in : vs_q;
    hs_rise = pix_tick && !hs_q && hsync_in;
    vs_rise = pix_tick && !vs_q && vsync_in;
    vs_fall = pix_tick && vs_q && !vsync_in;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StWaitVs;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the porch and x/y counters that steer it; enable=0 wins,
  // then a vsync fall restarts the frame from any state.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    if (!en_d) begin
      state_d = StWaitVs;
    end else if (vs_fall) begin
      state_d = StInVs;
      x_d     = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        StWaitVs: state_d = StWaitVs;
        StInVs: begin
          if (vs_rise) begin
            state_d = StVBack;
            cnt_d   = '0;
          end
        end
        StVBack: begin
          if (hs_rise) begin
            if (cnt_q == VBpLast) begin
              state_d = StHBack;
              y_d     = '0;
              cnt_d   = 10'd1;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
        end
        StHBack: begin
          if (pix_tick) begin
            if (cnt_q >= HBpLast) begin
              state_d = StHAct;
              x_d     = '0;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
        end
        StHAct: begin
          if (pix_tick) begin
            if (x_q == XLast) begin
              state_d = StHWait;
              x_d     = '0;
            end else begin
              x_d = x_q + 10'd1;
            end
          end
        end
        StHWait: begin
          if (hs_rise) begin
            if (y_q == YLast) begin
              state_d = StWaitVs;
            end else begin
              state_d = StHBack;
              y_d     = y_q + 10'd1;
              cnt_d   = 10'd1;
            end
          end
        end
        default: state_d = StWaitVs;
      endcase
    end
  end

  // FSM outputs: push one word per active pixel tick.
  always_comb begin
    push        = (state_q == StHAct) && pix_tick && en_d && !vs_fall;
    frame_start = (x_q == '0) && (y_q == '0);
  end

  // Counters, enable bit and sync sample registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  chu_vcap_fifo #(
    .Width(CD + 1),
    .AddrW(FIFO_AW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .pop_i  (so_ready),
    .wdata_i({rgb_in, frame_start}),
    .rdata_o(so_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .drop_o (drop)
  );

  assign so_valid = !fifo_empty;

`ifdef VCAP_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Sticky dropped-pixel flag; a ctrl write with bit1 set clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (ctrl_wr && wr_data[CtrlOvfClrBit]) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  logic unused_bits;
  assign unused_bits = ^{wr_data[31:2], addr[13:2], fifo_full};
`else
  assign overflow = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{wr_data[31:1], addr[13:2], fifo_full, drop};
`endif

endmodule

// File: tb/tb_chu_vga_capture_core.sv
// Directed bench for chu_vga_capture_core using a reduced 10x6 frame geometry.
module tb_chu_vga_capture_core;

  localparam int CD      = 12;
  localparam int HMAX    = 10;
  localparam int VMAX    = 6;
  localparam int H_BP    = 3;
  localparam int V_BP    = 2;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 2 ** FIFO_AW;

`ifdef VCAP_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_tick = 1'b0;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic [CD-1:0] rgb_in = '0;
  logic          cs = 1'b0;
  logic          write = 1'b0;
  logic [13:0]   addr = '0;
  logic [31:0]   wr_data = '0;
  logic [CD:0]   so_data;
  logic          so_valid;
  logic          so_ready = 1'b0;
  logic          overflow;

  int checks = 0;
  int failures = 0;
  logic [CD:0] exp_q[$];
  logic [CD:0] got_q[$];
  bit mon_en = 1'b0;
  bit cap = 1'b0;

  always #5 clk = ~clk;

  chu_vga_capture_core #(
    .CD(CD), .HMAX(HMAX), .VMAX(VMAX), .H_BP(H_BP), .V_BP(V_BP), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .rgb_in(rgb_in), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .overflow(overflow)
  );

  // Inputs change at posedge+1, so the negedge sees the values used at the next edge.
  always @(negedge clk) if (mon_en && so_valid && so_ready) got_q.push_back(so_data);

  function automatic logic [CD-1:0] pix_rgb(input int f, input int y, input int x);
    return CD'(f * 512 + y * 64 + x * 3 + 17);
  endfunction

  task automatic pt(input logic hs, input logic vs, input logic [CD-1:0] rgb);
    pix_tick = 1'b1; hsync_in = hs; vsync_in = vs; rgb_in = rgb;
    @(posedge clk); #1; pix_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    cs = 1'b1; write = 1'b1; addr = 14'd0; wr_data = v;
    @(posedge clk); #1; cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic drain();
    repeat (64) @(posedge clk);
    #1;
  endtask

  // Vsync pulse, then V_BP-1 porch hsync pulses; the next hsync begins line 0.
  task automatic send_vsync();
    pt(1'b1, 1'b0, '1); pt(1'b1, 1'b0, '1); pt(1'b1, 1'b1, '1);
    for (int i = 0; i < V_BP - 1; i++) begin
      pt(1'b0, 1'b1, '1); pt(1'b0, 1'b1, '1);
      repeat (3) pt(1'b1, 1'b1, '1);
    end
  endtask

  task automatic send_line(input int f, input int y, input int npix, input bit exp,
                           input int dis_x);
    pt(1'b0, 1'b1, '1); pt(1'b0, 1'b1, '1);
    for (int h = 0; h < H_BP; h++) pt(1'b1, 1'b1, '1);
    for (int x = 0; x < npix; x++) begin
      if (x == dis_x) begin
        wr_ctrl(32'd0);
        cap = 1'b0;
      end
      if (exp && cap) exp_q.push_back({pix_rgb(f, y, x), (x == 0 && y == 0)});
      pt(1'b1, 1'b1, pix_rgb(f, y, x));
    end
    if (npix == HMAX) begin
      pt(1'b1, 1'b1, '1); pt(1'b1, 1'b1, '1);
    end
  endtask

  task automatic send_frame(input int f, input int nlines, input int npart, input bit exp,
                            input int dis_y, input int dis_x);
    cap = 1'b1;
    send_vsync();
    for (int y = 0; y < nlines; y++) send_line(f, y, HMAX, exp, (y == dis_y) ? dis_x : -1);
    if (npart > 0) send_line(f, nlines, npart, exp, -1);
    if (nlines == VMAX) begin
      pt(1'b0, 1'b1, '1); pt(1'b0, 1'b1, '1); pt(1'b1, 1'b1, '1);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (so_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", so_valid); end
    checks++; if (so_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", so_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (so_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b want=0", so_valid); end
    mon_en = 1'b1;
  endtask

  task automatic test_full_frame();
    wr_ctrl(32'd1);
    so_ready = 1'b1;
    send_frame(0, VMAX, 0, 1'b1, -1, -1);
    drain();
    checks++; if (got_q.size() !== HMAX * VMAX) begin failures++; $display("FAIL frame_count got=%0d want=%0d", got_q.size(), HMAX * VMAX); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL frame_beat[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL frame_ovf got=%b want=0", overflow); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    so_ready = 1'b0;
    send_frame(1, 2, 0, 1'b0, -1, -1);
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({pix_rgb(1, i / HMAX, i % HMAX), (i == 0)});
    checks++; if (so_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b want=1", so_valid); end
    checks++; if (overflow !== OVF_EXP) begin failures++; $display("FAIL ovf_flag got=%b want=%b", overflow, OVF_EXP); end
    // Line 2: first pixel pushed while full with a simultaneous pop, rest dropped.
    pt(1'b0, 1'b1, '1); pt(1'b0, 1'b1, '1);
    for (int h = 0; h < H_BP; h++) pt(1'b1, 1'b1, '1);
    pix_tick = 1'b1; rgb_in = pix_rgb(1, 2, 0); so_ready = 1'b1;
    @(posedge clk); #1; pix_tick = 1'b0; so_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({pix_rgb(1, 2, 0), 1'b0});
    for (int x = 1; x < HMAX; x++) pt(1'b1, 1'b1, pix_rgb(1, 2, x));
    so_ready = 1'b1;
    drain();
    checks++; if (got_q.size() !== DEPTH + 1) begin failures++; $display("FAIL ovf_count got=%0d want=%0d", got_q.size(), DEPTH + 1); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_beat[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== OVF_EXP) begin failures++; $display("FAIL ovf_sticky got=%b want=%b", overflow, OVF_EXP); end
    wr_ctrl(32'd3);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_vsync_abort();
    so_ready = 1'b1;
    send_frame(4, 3, 4, 1'b1, -1, -1);
    send_frame(5, VMAX, 0, 1'b1, -1, -1);
    drain();
    checks++; if (got_q.size() !== 3 * HMAX + 4 + HMAX * VMAX) begin failures++; $display("FAIL abort_count got=%0d want=%0d", got_q.size(), 3 * HMAX + 4 + HMAX * VMAX); end
    if (got_q.size() > 3 * HMAX + 4) begin
      checks++; if (got_q[3 * HMAX + 4][0] !== 1'b1) begin failures++; $display("FAIL abort_restart_lsb got=%b want=1", got_q[3 * HMAX + 4][0]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_beat[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_enable_clear();
    so_ready = 1'b1;
    send_frame(2, 4, 0, 1'b1, 2, 5);
    wr_ctrl(32'd1);
    send_line(2, 4, HMAX, 1'b0, -1);
    send_line(2, 5, HMAX, 1'b0, -1);
    drain();
    checks++; if (got_q.size() !== 2 * HMAX + 5) begin failures++; $display("FAIL en_count got=%0d want=%0d", got_q.size(), 2 * HMAX + 5); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL en_beat[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    send_frame(3, VMAX, 0, 1'b1, -1, -1);
    drain();
    checks++; if (got_q.size() !== HMAX * VMAX) begin failures++; $display("FAIL en_resume_count got=%0d want=%0d", got_q.size(), HMAX * VMAX); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL en_resume_beat[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midline();
    so_ready = 1'b0;
    send_frame(6, 1, 4, 1'b0, -1, -1);
    checks++; if (so_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b want=1", so_valid); end
    reset = 1'b0;
    #1;
    checks++; if (so_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", so_valid); end
    checks++; if (so_data !== '0) begin failures++; $display("FAIL rst_mid_data got=%h want=0", so_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf got=%b want=0", overflow); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    so_ready = 1'b1;
    wr_ctrl(32'd1);
    send_line(6, 2, HMAX, 1'b0, -1);
    send_line(6, 3, HMAX, 1'b0, -1);
    drain();
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rst_no_beats got=%0d want=0", got_q.size()); end
    got_q.delete();
    send_frame(0, VMAX, 0, 1'b1, -1, -1);
    drain();
    checks++; if (got_q.size() !== HMAX * VMAX) begin failures++; $display("FAIL rst_frame_count got=%0d want=%0d", got_q.size(), HMAX * VMAX); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_frame_beat[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_vsync_abort();
    test_enable_clear();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
